// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: forwarding encodings,
// multiply/divide sequencer states, default latencies and a register-match helper.
package mips_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_STALL_W = 32;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int unsigned DEFAULT_MULT_CYCLES = 4;
    localparam int unsigned DEFAULT_DIV_CYCLES  = 32;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    // A write to $0 never produces a dependency.
    function automatic logic reg_match(input logic we,
                                       input logic [REG_W-1:0] dst,
                                       input logic [REG_W-1:0] src);
        return we && (src != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/md_sequencer.sv
// Multi-cycle MULT/DIV sequencer: tracks the busy window of the unit that owns
// HI/LO and pulses md_done in the cycle the result commits.
module md_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy,
    output logic md_done
);

    localparam int unsigned MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT);

    md_state_t          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Count holds the cycles remaining after the current one; zero marks the commit cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        md_busy = 1'b0;
        md_done = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    state_d = MD_BUSY;
                    count_d = md_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                end
            end
            MD_BUSY: begin
                md_busy = 1'b1;
                if (count_q == '0) begin
                    md_done = 1'b1;
                    state_d = MD_IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // A new op cannot reach E while HI/LO is busy; if one does, it is dropped.
    md_start_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
                                          !(md_start && (state_q == MD_BUSY)))
        else $error("md_sequencer: MdStart_E asserted while MULT/DIV busy");

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, load-use/branch/HI-LO stalls,
// redirect flushes, MULT/DIV sequencing and a saturating stall-cycle counter.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_W-1:0]       Rs_D,
    input  logic [REG_W-1:0]       Rt_D,
    input  logic [REG_W-1:0]       Rs_E,
    input  logic [REG_W-1:0]       Rt_E,
    input  logic [REG_W-1:0]       WriteReg_E,
    input  logic [REG_W-1:0]       WriteReg_M,
    input  logic [REG_W-1:0]       WriteReg_W,
    input  logic                   RegWrite_E,
    input  logic                   RegWrite_M,
    input  logic                   RegWrite_W,
    input  logic                   MemtoReg_E,
    input  logic                   MemtoReg_M,
    input  logic                   Branch_D,
    input  logic                   Jr_D,
    input  logic                   Jump_D,
    input  logic                   BranchTaken_D,
    input  logic                   HiloAccess_D,
    input  logic                   MdStart_E,
    input  logic                   MdIsDiv_E,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   FlushD,
    output logic                   FlushE,
    output logic [1:0]             ForwardAE,
    output logic [1:0]             ForwardBE,
    output logic                   ForwardAD,
    output logic                   ForwardBD,
    output logic                   md_busy,
    output logic                   md_done,
    output logic [CNT_STALL_W-1:0] stall_cycles
);

    logic lwstall, brstall, mdstall, stall;
    logic rs_dep_d, rt_dep_d, redirect_d;

    md_sequencer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_sequencer (
        .clk       (clk),
        .rst_n     (rst_n),
        .md_start  (MdStart_E),
        .md_is_div (MdIsDiv_E),
        .md_busy   (md_busy),
        .md_done   (md_done)
    );

    // M-stage result is newer than W, so it wins.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (reg_match(RegWrite_M, WriteReg_M, Rs_E))      ForwardAE = FWD_MEM;
        else if (reg_match(RegWrite_W, WriteReg_W, Rs_E)) ForwardAE = FWD_WB;
        if (reg_match(RegWrite_M, WriteReg_M, Rt_E))      ForwardBE = FWD_MEM;
        else if (reg_match(RegWrite_W, WriteReg_W, Rt_E)) ForwardBE = FWD_WB;
    end

    assign ForwardAD = reg_match(RegWrite_M, WriteReg_M, Rs_D);
    assign ForwardBD = reg_match(RegWrite_M, WriteReg_M, Rt_D);

    assign lwstall = MemtoReg_E && (reg_match(1'b1, Rt_E, Rs_D) || reg_match(1'b1, Rt_E, Rt_D));

    // D-stage comparator can only take the M ALU result, not E results or M loads.
    assign rs_dep_d = reg_match(RegWrite_E, WriteReg_E, Rs_D) || reg_match(MemtoReg_M, WriteReg_M, Rs_D);
    assign rt_dep_d = reg_match(RegWrite_E, WriteReg_E, Rt_D) || reg_match(MemtoReg_M, WriteReg_M, Rt_D);
    assign brstall  = ((Branch_D || Jr_D) && rs_dep_d) || (Branch_D && rt_dep_d);

    assign mdstall  = HiloAccess_D && md_busy && !md_done;

    assign stall  = lwstall || brstall || mdstall;
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    assign redirect_d = (BranchTaken_D && Branch_D) || Jump_D || Jr_D;
    assign FlushD     = redirect_d && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a cycle-level reference model checked
// every negedge, plus directed scenarios with hand-computed expectations.
module tb_hazard_unit;
    import mips_pkg::*;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
    logic RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M;
    logic Branch_D, Jr_D, Jump_D, BranchTaken_D, HiloAccess_D, MdStart_E, MdIsDiv_E;
    logic StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, md_busy, md_done;
    logic [1:0] ForwardAE, ForwardBE;
    logic [31:0] stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_unit #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
        .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M),
        .Branch_D(Branch_D), .Jr_D(Jr_D), .Jump_D(Jump_D), .BranchTaken_D(BranchTaken_D),
        .HiloAccess_D(HiloAccess_D), .MdStart_E(MdStart_E), .MdIsDiv_E(MdIsDiv_E),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .md_busy(md_busy), .md_done(md_done), .stall_cycles(stall_cycles)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_active = 1'b0;
    int          m_elapsed = 0;
    int          m_lat = MULT_LAT;
    logic [31:0] m_stalls = 32'd0;

    function automatic bit hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return (we === 1'b1) && (src != 5'd0) && (dst == src);
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (hit(RegWrite_M, WriteReg_M, src)) return 2'b10;
        if (hit(RegWrite_W, WriteReg_W, src)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit d_reads_stale(input logic [4:0] src);
        return hit(RegWrite_E, WriteReg_E, src) || hit(MemtoReg_M, WriteReg_M, src);
    endfunction

    function automatic bit exp_done();
        return m_active && (m_elapsed == m_lat);
    endfunction

    function automatic bit exp_stall();
        bit lw, br, md;
        lw = MemtoReg_E && (hit(1'b1, Rt_E, Rs_D) || hit(1'b1, Rt_E, Rt_D));
        br = 1'b0;
        if (Branch_D || Jr_D) br = br || d_reads_stale(Rs_D);
        if (Branch_D)         br = br || d_reads_stale(Rt_D);
        md = HiloAccess_D && m_active && !exp_done();
        return lw || br || md;
    endfunction

    function automatic bit exp_flushd();
        return ((BranchTaken_D && Branch_D) || Jump_D || Jr_D) && !exp_stall();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active  = 1'b0;
            m_elapsed = 0;
            m_stalls  = 32'd0;
        end else begin
            if (exp_stall() && (m_stalls != 32'hFFFF_FFFF)) m_stalls = m_stalls + 32'd1;
            if (m_active) begin
                if (m_elapsed == m_lat) m_active = 1'b0;
                else                    m_elapsed = m_elapsed + 1;
            end else if (MdStart_E) begin
                m_active  = 1'b1;
                m_elapsed = 1;
                m_lat     = MdIsDiv_E ? DIV_LAT : MULT_LAT;
            end
        end
    end

    always @(negedge clk) begin
        check("model_StallF", StallF, exp_stall());
        check("model_StallD", StallD, exp_stall());
        check("model_FlushE", FlushE, exp_stall());
        check("model_FlushD", FlushD, exp_flushd());
        check("model_ForwardAE", ForwardAE, exp_fwd(Rs_E));
        check("model_ForwardBE", ForwardBE, exp_fwd(Rt_E));
        check("model_ForwardAD", ForwardAD, hit(RegWrite_M, WriteReg_M, Rs_D));
        check("model_ForwardBD", ForwardBD, hit(RegWrite_M, WriteReg_M, Rt_D));
        check("model_md_busy", md_busy, m_active);
        check("model_md_done", md_done, exp_done());
        check("model_stall_cycles", stall_cycles, m_stalls);
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_inputs();
        Rs_D = 0; Rt_D = 0; Rs_E = 0; Rt_E = 0;
        WriteReg_E = 0; WriteReg_M = 0; WriteReg_W = 0;
        RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
        MemtoReg_E = 0; MemtoReg_M = 0;
        Branch_D = 0; Jr_D = 0; Jump_D = 0; BranchTaken_D = 0;
        HiloAccess_D = 0; MdStart_E = 0; MdIsDiv_E = 0;
    endtask

    task automatic cyc_start();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_stall_cycles", stall_cycles, 32'd0);
        check("reset_md_busy", md_busy, 1'b0);
        check("reset_StallD", StallD, 1'b0);
        cyc_start(); rst_n = 1'b1;

        // forwarding priority and $0
        cyc_start(); RegWrite_M = 1; WriteReg_M = 8; RegWrite_W = 1; WriteReg_W = 8; Rs_E = 8;
        @(negedge clk); check("fwdAE_mem_priority", ForwardAE, 2'b10);
        cyc_start(); RegWrite_W = 1; WriteReg_W = 8; Rs_E = 8;
        @(negedge clk); check("fwdAE_wb", ForwardAE, 2'b01);
        cyc_start(); RegWrite_M = 1; WriteReg_M = 0; RegWrite_W = 1; WriteReg_W = 0;
        @(negedge clk); check("fwdAE_r0", ForwardAE, 2'b00); check("fwdAD_r0", ForwardAD, 1'b0);
        cyc_start(); Rt_E = 3; RegWrite_W = 1; WriteReg_W = 3; Rt_D = 7; RegWrite_M = 1; WriteReg_M = 7;
        @(negedge clk); check("fwdBE_wb", ForwardBE, 2'b01); check("fwdBD_mem", ForwardBD, 1'b1);
        check("fwdAD_none", ForwardAD, 1'b0);

        // load-use
        cyc_start(); MemtoReg_E = 1; RegWrite_E = 1; Rt_E = 9; WriteReg_E = 9; Rt_D = 9;
        @(negedge clk); check("lw_StallF", StallF, 1'b1); check("lw_StallD", StallD, 1'b1);
        check("lw_FlushE", FlushE, 1'b1);
        cyc_start(); MemtoReg_M = 1; RegWrite_M = 1; WriteReg_M = 9; Rt_E = 9;
        @(negedge clk); check("lw_released", StallD, 1'b0); check("lw_stall_cycles", stall_cycles, 32'd1);
        check("lw_fwdBE_mem", ForwardBE, 2'b10);
        cyc_start(); RegWrite_W = 1; WriteReg_W = 9; Rt_E = 9;
        @(negedge clk); check("lw_fwdBE_wb", ForwardBE, 2'b01); check("lw_no_stall", StallD, 1'b0);
        cyc_start(); MemtoReg_E = 1; Rt_E = 0;
        @(negedge clk); check("lw_r0_no_stall", StallD, 1'b0);

        // branch / jr / jump
        cyc_start(); Branch_D = 1; BranchTaken_D = 1; Rs_D = 5; RegWrite_E = 1; WriteReg_E = 5;
        @(negedge clk); check("beq_stall", StallD, 1'b1); check("beq_flush_held", FlushD, 1'b0);
        cyc_start(); Branch_D = 1; BranchTaken_D = 1; Rs_D = 5; RegWrite_M = 1; WriteReg_M = 5;
        @(negedge clk); check("beq_redirect", FlushD, 1'b1); check("beq_no_stall", StallD, 1'b0);
        check("beq_fwdAD", ForwardAD, 1'b1); check("beq_stall_cycles", stall_cycles, 32'd2);
        cyc_start(); Jr_D = 1; Rs_D = 4; MemtoReg_M = 1; RegWrite_M = 1; WriteReg_M = 4;
        @(negedge clk); check("jr_load_stall", StallD, 1'b1); check("jr_flush_held", FlushD, 1'b0);
        cyc_start(); Jr_D = 1; Rt_D = 6; RegWrite_E = 1; WriteReg_E = 6;
        @(negedge clk); check("jr_ignores_rt", StallD, 1'b0); check("jr_flush", FlushD, 1'b1);
        check("jr_stall_cycles", stall_cycles, 32'd3);
        cyc_start(); Jump_D = 1;
        @(negedge clk); check("j_flush", FlushD, 1'b1);
        cyc_start(); Branch_D = 1; BranchTaken_D = 0; Rs_D = 2;
        @(negedge clk); check("bnt_no_flush", FlushD, 1'b0);

        // MULT with HI/LO consumer waiting in D
        cyc_start(); MdStart_E = 1; HiloAccess_D = 1;
        @(negedge clk); check("mult_t_busy", md_busy, 1'b0); check("mult_t_stall", StallD, 1'b0);
        for (int k = 1; k <= MULT_LAT; k++) begin
            cyc_start(); HiloAccess_D = 1;
            @(negedge clk);
            check("mult_busy", md_busy, 1'b1);
            check("mult_done", md_done, (k == MULT_LAT) ? 1'b1 : 1'b0);
            check("mult_stall", StallD, (k < MULT_LAT) ? 1'b1 : 1'b0);
        end
        cyc_start(); HiloAccess_D = 1;
        @(negedge clk); check("mult_after_busy", md_busy, 1'b0);
        check("mult_stall_cycles", stall_cycles, 32'd6);

        // full DIV
        cyc_start(); MdStart_E = 1; MdIsDiv_E = 1;
        for (int k = 1; k <= DIV_LAT; k++) begin
            cyc_start();
            @(negedge clk);
            check("div_busy", md_busy, 1'b1);
            check("div_done", md_done, (k == DIV_LAT) ? 1'b1 : 1'b0);
        end
        cyc_start();
        @(negedge clk); check("div_after_busy", md_busy, 1'b0);

        // DIV abandoned by reset at t+10
        cyc_start(); MdStart_E = 1; MdIsDiv_E = 1;
        for (int k = 1; k <= 9; k++) begin
            cyc_start();
            @(negedge clk); check("div_abort_busy", md_busy, 1'b1);
        end
        cyc_start(); rst_n = 1'b0;
        #1; check("abort_busy_immediate", md_busy, 1'b0);
        @(negedge clk);
        check("abort_done", md_done, 1'b0); check("abort_stall_cycles", stall_cycles, 32'd0);
        cyc_start(); rst_n = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cyc_start();
            @(negedge clk); check("abort_no_done", md_done, 1'b0);
        end
        cyc_start(); MdStart_E = 1;
        for (int k = 1; k <= MULT_LAT; k++) begin
            cyc_start();
            @(negedge clk);
            check("post_reset_mult_done", md_done, (k == MULT_LAT) ? 1'b1 : 1'b0);
        end
        cyc_start();
        @(negedge clk); check("post_reset_idle", md_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
